// File: rtl/perceptron_introduction_pkg.sv
// Q16.16 signed fixed-point type, constants and arithmetic helpers for the perceptron.
// Define PERCEPTRON_SAT_EN to make sfp_mul/sfp_add saturate; otherwise they wrap modulo 2^32.
package FixedPoint;

    typedef logic signed [31:0] sfp;

    localparam int FRAC_BITS = 16;
    localparam sfp ONE       = 32'sh0001_0000;
    localparam sfp SFP_MAX   = 32'sh7FFF_FFFF;
    localparam sfp SFP_MIN   = 32'sh8000_0000;

    function automatic sfp int_to_sfp(input int v);
        return sfp'(v <<< FRAC_BITS);
    endfunction

    function automatic sfp sfp_mul(input sfp a, input sfp b);
`ifdef PERCEPTRON_SAT_EN
        logic signed [63:0] s;
        s = (64'($signed(a)) * 64'($signed(b))) >>> FRAC_BITS;
        if (s > 64'sh0000_0000_7FFF_FFFF) begin
            return SFP_MAX;
        end else if (s < -64'sh0000_0000_8000_0000) begin
            return SFP_MIN;
        end else begin
            return sfp'(s);
        end
`else
        return sfp'((64'($signed(a)) * 64'($signed(b))) >>> FRAC_BITS);
`endif
    endfunction

    function automatic sfp sfp_add(input sfp a, input sfp b);
`ifdef PERCEPTRON_SAT_EN
        logic signed [32:0] s;
        s = 33'($signed(a)) + 33'($signed(b));
        // A carry into bit 32 that disagrees with bit 31 means the 32-bit result overflowed.
        if (s[32] != s[31]) begin
            return s[32] ? SFP_MIN : SFP_MAX;
        end else begin
            return sfp'(s);
        end
`else
        return a + b;
`endif
    endfunction

endpackage

// File: rtl/perceptron_introduction_dot.sv
// Combinational weighted sum: sum = bias + SUM_i w[i]*x[i] in Q16.16.
// Overflow behaviour follows PERCEPTRON_SAT_EN through the FixedPoint helpers.
module perceptron_dot
    import FixedPoint::*;
#(
    parameter int input_units = 2
) (
    input  sfp weights [input_units],
    input  sfp bias,
    input  sfp values  [input_units],
    output sfp sum
);

    sfp acc_s;

    // Bias first, then each product, so saturation order is fixed.
    always_comb begin
        acc_s = bias;
        for (int i = 0; i < input_units; i++) begin
            acc_s = sfp_add(acc_s, sfp_mul(weights[i], values[i]));
        end
        sum = acc_s;
    end

endmodule

// File: rtl/perceptron_introduction.sv
// Single-layer perceptron with step activation and online perceptron-rule learning.
// PERCEPTRON_SAT_EN selects saturating instead of wrapping arithmetic.
module perceptron_introduction
    import FixedPoint::*;
#(
    parameter int input_units = 2
) (
    input  logic clk,
    input  logic rst,
    input  sfp   values [input_units],
    input  logic training,
    input  sfp   learning_rate,
    input  sfp   expected,
    output sfp   prediction
);

    sfp weights_r [input_units];
    sfp bias_r;
    sfp prediction_r;
    sfp sum_s;
    sfp y_s;
    sfp err_s;
    sfp delta_s;

    perceptron_dot #(.input_units(input_units)) u_dot (
        .weights (weights_r),
        .bias    (bias_r),
        .values  (values),
        .sum     (sum_s)
    );

    // Step activation and the learning delta, both from the same-cycle classification.
    always_comb begin
        y_s     = (sum_s > 32'sd0) ? ONE : 32'sd0;
        err_s   = expected - y_s;
        delta_s = sfp_mul(learning_rate, err_s);
    end

    // Weight/bias state and the registered prediction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < input_units; i++) begin
                weights_r[i] <= 32'sd0;
            end
            bias_r       <= 32'sd0;
            prediction_r <= 32'sd0;
        end else begin
            prediction_r <= y_s;
            if (training) begin
                for (int i = 0; i < input_units; i++) begin
                    weights_r[i] <= sfp_add(weights_r[i], sfp_mul(delta_s, values[i]));
                end
                bias_r <= sfp_add(bias_r, delta_s);
            end else begin
                bias_r <= bias_r;
            end
        end
    end

    assign prediction = prediction_r;

endmodule

// File: tb/tb_perceptron_introduction.sv
// Self-checking bench for perceptron_introduction: directed scenarios plus randomized traffic
// compared against a 64-bit integer reference model of the perceptron rule.
module tb_perceptron_introduction;

    localparam int N = 2;
    localparam logic signed [31:0] ONE_C = 32'sh0001_0000;

    logic clk = 1'b0;
    logic rst;
    logic signed [31:0] values [N];
    logic training;
    logic signed [31:0] learning_rate;
    logic signed [31:0] expected;
    logic signed [31:0] prediction;

    int checks = 0;
    int errors = 0;

    logic signed [31:0] mw [N];
    logic signed [31:0] mb;
    logic signed [31:0] mpred;
    logic signed [31:0] saved_w [N];
    logic signed [31:0] saved_b;

    perceptron_introduction #(.input_units(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .values        (values),
        .training      (training),
        .learning_rate (learning_rate),
        .expected      (expected),
        .prediction    (prediction)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] fit(input longint v);
        logic signed [31:0] r;
`ifdef PERCEPTRON_SAT_EN
        if (v > 64'sd2147483647) r = 32'sh7FFF_FFFF;
        else if (v < -64'sd2147483648) r = 32'sh8000_0000;
        else r = v[31:0];
`else
        r = v[31:0];
`endif
        return r;
    endfunction

    function automatic logic signed [31:0] m_mul(input logic signed [31:0] a, input logic signed [31:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return fit(p >>> 16);
    endfunction

    function automatic logic signed [31:0] m_add(input logic signed [31:0] a, input logic signed [31:0] b);
        return fit(longint'(a) + longint'(b));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model with the inputs present at the edge, then compare.
    task automatic step(input string tag);
        logic signed [31:0] s, y, d;
        if (rst) begin
            for (int i = 0; i < N; i++) mw[i] = 32'sd0;
            mb = 32'sd0;
            mpred = 32'sd0;
        end else begin
            s = mb;
            for (int i = 0; i < N; i++) s = m_add(s, m_mul(mw[i], values[i]));
            y = (s > 0) ? ONE_C : 32'sd0;
            if (training) begin
                d = m_mul(learning_rate, expected - y);
                for (int i = 0; i < N; i++) mw[i] = m_add(mw[i], m_mul(d, values[i]));
                mb = m_add(mb, d);
            end
            mpred = y;
        end
        @(posedge clk);
        #1;
        check({tag, ".pred"}, prediction, mpred);
        check({tag, ".w0"}, dut.weights_r[0], mw[0]);
        check({tag, ".w1"}, dut.weights_r[1], mw[1]);
        check({tag, ".b"}, dut.bias_r, mb);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        training = 1'b0;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic set_and(input int p);
        values[0] = p[1] ? ONE_C : 32'sd0;
        values[1] = p[0] ? ONE_C : 32'sd0;
        expected  = (p == 3) ? ONE_C : 32'sd0;
    endtask

    initial begin
        rst = 1'b1;
        training = 1'b0;
        learning_rate = 32'sd0;
        expected = 32'sd0;
        for (int i = 0; i < N; i++) begin
            values[i] = 32'sd0;
            mw[i] = 32'sd0;
        end
        mb = 32'sd0;
        mpred = 32'sd0;
        @(negedge clk);

        // 1: untrained, sum == 0 must classify as 0
        do_reset();
        check("reset_pred", prediction, 32'h0);
        values[0] = ONE_C;
        values[1] = ONE_C;
        for (int k = 0; k < 3; k++) begin
            step("zero_sum");
            check("zero_sum_pred", prediction, 32'h0);
        end

        // 2: single update
        training = 1'b1;
        learning_rate = ONE_C;
        expected = ONE_C;
        step("single");
        check("single_w0", dut.weights_r[0], ONE_C);
        check("single_b", dut.bias_r, ONE_C);
        training = 1'b0;
        step("single_next");
        check("single_pred", prediction, ONE_C);

        // 3: learn AND, then verify all four patterns
        do_reset();
        training = 1'b1;
        learning_rate = ONE_C;
        for (int k = 0; k < 40; k++) begin
            set_and(k % 4);
            step("and_train");
        end
        training = 1'b0;
        for (int p = 0; p < 4; p++) begin
            set_and(p);
            step("and_eval");
            check("and_pred", prediction, (p == 3) ? ONE_C : 32'h0);
        end

        // 4: frozen state with wrong labels
        saved_w[0] = mw[0];
        saved_w[1] = mw[1];
        saved_b = mb;
        for (int k = 0; k < 10; k++) begin
            set_and(k % 4);
            expected = (k % 4 == 3) ? 32'sd0 : ONE_C;
            step("freeze");
            check("freeze_pred", prediction, (k % 4 == 3) ? ONE_C : 32'h0);
        end
        check("freeze_w0", dut.weights_r[0], saved_w[0]);
        check("freeze_w1", dut.weights_r[1], saved_w[1]);
        check("freeze_b", dut.bias_r, saved_b);

        // 5: half learning rate
        do_reset();
        training = 1'b1;
        learning_rate = 32'sh0000_8000;
        values[0] = ONE_C;
        values[1] = 32'sd0;
        expected = ONE_C;
        step("half");
        check("half_w0", dut.weights_r[0], 32'h0000_8000);
        check("half_w1", dut.weights_r[1], 32'h0);
        check("half_b", dut.bias_r, 32'h0000_8000);

        // 6: overflow of w[0] on the second update
        do_reset();
        training = 1'b1;
        learning_rate = ONE_C;
        values[0] = ONE_C;
        values[1] = 32'sd0;
        expected = 32'sh7FFF_0000;
        step("ovf1");
        check("ovf1_w0", dut.weights_r[0], 32'h7FFF_0000);
        step("ovf2");
`ifdef PERCEPTRON_SAT_EN
        check("ovf_w0_clamp", dut.weights_r[0], 32'h7FFF_FFFF);
`else
        check("ovf_w0_wrap", dut.weights_r[0], 32'hFFFE_0000);
`endif

        // Randomized traffic with occasional resets, mixing small and full-range operands
        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            training = $urandom_range(0, 1) == 1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) values[i] = $urandom;
                else values[i] = $signed($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
            end
            learning_rate = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h0001_0000);
            case ($urandom_range(0, 3))
                0: expected = 32'sd0;
                1: expected = ONE_C;
                2: expected = $urandom;
                default: expected = ONE_C;
            endcase
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
